// File: rtl/nibble_serial_addsub_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_addsub_ctrl
//
// Purpose:
//   Drives one external 4-bit adder/subtractor to perform a WIDTH-bit add or
//   subtract, one nibble per clock, least significant nibble first. The carry
//   between nibbles is kept in a register. Operands come in over a
//   valid/ready handshake. Sum, final carry and signed overflow go out over a
//   second valid/ready handshake.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    request handshake; in_ready is high only in IDLE
//   in_a, in_b, in_op    operands; in_op 0 = A+B, 1 = A-B
//   out_valid/out_ready  result handshake; out_valid is high only in DONE
//   out_sum              WIDTH-bit result
//   out_carry            final carry out (subtract: 1 = no borrow)
//   out_ovf              signed two's-complement overflow
//   busy                 high in RUN or DONE
//   dp_a, dp_b, dp_cin   nibble operands and carry-in to the external datapath
//   dp_s, dp_cout, dp_v  combinational sum, carry-out and overflow from it
//
// State table:
//   state   | meaning
//   IDLE    | waiting for a request; in_ready=1, datapath inputs driven to 0
//   RUN     | one nibble per cycle through the datapath, idx = current nibble
//   DONE    | result held on out_* with out_valid=1 until out_ready
// ----------------------------------------------------------------------------
module nibble_serial_addsub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             busy,
  output logic [3:0]       dp_a,
  output logic [3:0]       dp_b,
  output logic             dp_cin,
  input  logic [3:0]       dp_s,
  input  logic             dp_cout,
  input  logic             dp_v
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operands and result are kept as nibble arrays so the current nibble is
  // addressed directly by idx.
  logic [NIBBLES-1:0][3:0] a_q;
  logic [NIBBLES-1:0][3:0] b_q;
  logic [NIBBLES-1:0][3:0] sum_q;
  logic                    op_q;
  logic                    carry_q;
  logic                    ovf_q;
  logic [IDXW-1:0]         idx_q;

  logic accept;
  logic step;
  logic last_step;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, handshake outputs and datapath drive
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    dp_a      = 4'h0;
    dp_b      = 4'h0;
    dp_cin    = 1'b0;
    last_step = (idx_q == LAST_IDX);

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        busy   = 1'b1;
        step   = 1'b1;
        dp_a   = a_q[idx_q];
        // Subtract is A + ~B + 1; the +1 arrives through the carry register,
        // which is preloaded with op on accept.
        dp_b   = b_q[idx_q] ^ {4{op_q}};
        dp_cin = carry_q;
        if (last_step) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand, result, carry and nibble-index registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b;
      op_q    <= in_op;
      carry_q <= in_op;
      idx_q   <= '0;
    end else if (step) begin
      sum_q[idx_q] <= dp_s;
      carry_q      <= dp_cout;
      ovf_q        <= dp_v;
      // Hold on the last nibble so idx never wraps within an operation.
      if (!last_step) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // In DONE the carry register holds the final dp_cout and ovf_q the final
  // dp_v, so the result registers feed the outputs directly.
  assign out_sum   = sum_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
module tb_nibble_serial_addsub_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_carry;
  logic        out_ovf;
  logic        busy;
  logic [3:0]  dp_a;
  logic [3:0]  dp_b;
  logic        dp_cin;
  logic [3:0]  dp_s;
  logic        dp_cout;
  logic        dp_v;

  int n_pass;
  int n_total;

  nibble_serial_addsub_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .busy      (busy),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_cin    (dp_cin),
    .dp_s      (dp_s),
    .dp_cout   (dp_cout),
    .dp_v      (dp_v)
  );

  // External 4-bit datapath
  logic [4:0] dp_full;
  logic [3:0] dp_low3;
  assign dp_full = {1'b0, dp_a} + {1'b0, dp_b} + {4'b0, dp_cin};
  assign dp_low3 = {1'b0, dp_a[2:0]} + {1'b0, dp_b[2:0]} + {3'b0, dp_cin};
  assign dp_s    = dp_full[3:0];
  assign dp_cout = dp_full[4];
  assign dp_v    = dp_full[4] ^ dp_low3[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Whole-word reference: {carry, ovf, sum}
  function automatic logic [17:0] ref_model(input logic op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] full;
    logic [15:0] s;
    logic        ovf;
    if (op) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else    full = {1'b0, a} + {1'b0, b};
    s = full[15:0];
    if (op) ovf = (a[15] != b[15]) && (s[15] != a[15]);
    else    ovf = (a[15] == b[15]) && (s[15] != a[15]);
    return {full[16], ovf, s};
  endfunction

  // Ends on the negedge of the first RUN cycle, returning datapath drive there.
  task automatic start_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          output logic [3:0] fa, output logic [3:0] fb, output logic fcin);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_op    = 1'($urandom);
    fa   = dp_a;
    fb   = dp_b;
    fcin = dp_cin;
  endtask

  // Counts edges from the accept edge (counted as 1) until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [15:0] s, output logic c, output logic v, output int lat,
                        output logic [3:0] fb, output logic fcin);
    logic [3:0] fa;
    start_op(op, a, b, fa, fb, fcin);
    wait_valid(lat);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
    end
    s = out_sum;
    c = out_carry;
    v = out_ovf;
    finish_op();
  endtask

  typedef struct packed {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    logic [15:0] s;
    logic        c, v, fcin;
    logic [3:0]  fa, fb;
    logic [17:0] exp;
    logic [15:0] ra, rb;
    logic        rop;
    int          lat;
    int          tacc [2];
    int          nacc;
    logic        seen;

    n_pass = 0;
    n_total = 0;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 16'h0;
    in_b = 16'h0;
    in_op = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_sum", 32'(out_sum), 32'd0);
    check("rst out_carry", 32'(out_carry), 32'd0);
    check("rst out_ovf", 32'(out_ovf), 32'd0);
    check("rst dp_b", 32'(dp_b), 32'd0);
    check("rst dp_cin", 32'(dp_cin), 32'd0);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, s, c, v, lat, fb, fcin);
      check("vec sum", 32'(s), 32'(vecs[i].sum));
      check("vec carry", 32'(c), 32'(vecs[i].carry));
      check("vec ovf", 32'(v), 32'(vecs[i].ovf));
      check("vec latency", 32'(lat), 32'd5);
      check("vec first dp_b", 32'(fb), 32'(vecs[i].b[3:0] ^ {4{vecs[i].op}}));
      check("vec first dp_cin", 32'(fcin), 32'(vecs[i].op));
    end

    // Subtract first-cycle datapath drive
    start_op(1'b1, 16'h0005, 16'h0007, fa, fb, fcin);
    check("sub dp_a", 32'(fa), 32'h5);
    check("sub dp_b", 32'(fb), 32'h8);
    check("sub dp_cin", 32'(fcin), 32'd1);
    check("run busy", 32'(busy), 32'd1);
    check("run in_ready", 32'(in_ready), 32'd0);
    wait_valid(lat);
    finish_op();

    // Result held in DONE while out_ready is low; in_valid is ignored
    start_op(1'b0, 16'h1234, 16'h0FFF, fa, fb, fcin);
    wait_valid(lat);
    check("hold latency", 32'(lat), 32'd5);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_a = 16'hAAAA;
      in_b = 16'h5555;
      in_op = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold out_sum", 32'(out_sum), 32'h2233);
      check("hold out_carry", 32'(out_carry), 32'd0);
      check("hold out_ovf", 32'(out_ovf), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release in_ready", 32'(in_ready), 32'd1);
    check("release out_valid", 32'(out_valid), 32'd0);
    check("release busy", 32'(busy), 32'd0);
    check("release dp_a", 32'(dp_a), 32'd0);

    // Reset in the middle of RUN at idx=2
    start_op(1'b0, 16'h1234, 16'h1111, fa, fb, fcin);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("idx2 dp_a", 32'(dp_a), 32'h2);
    check("idx2 dp_b", 32'(dp_b), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort out_sum", 32'(out_sum), 32'd0);
    check("abort out_carry", 32'(out_carry), 32'd0);
    check("abort out_ovf", 32'(out_ovf), 32'd0);
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    check("abort no out_valid", 32'(seen), 32'd0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 0, s, c, v, lat, fb, fcin);
    check("post-abort sum", 32'(s), 32'h0000);
    check("post-abort carry", 32'(c), 32'd1);
    check("post-abort ovf", 32'(v), 32'd0);

    // Back-to-back throughput with in_valid and out_ready held high
    nacc = 0;
    tacc[0] = 0;
    tacc[1] = 0;
    in_valid = 1'b1;
    in_a = 16'h0101;
    in_b = 16'h0202;
    in_op = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (nacc >= 2) in_valid = 1'b0;
      else if (in_ready) begin
        tacc[nacc] = cyc;
        nacc++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("b2b accepts", 32'(nacc), 32'd2);
    check("b2b period", 32'(tacc[1] - tacc[0]), 32'd6);
    check("b2b idle", 32'(in_ready), 32'd1);

    // Random operations against the whole-word reference
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (i % 8 == 0) rb = ra;
      run_op(rop, ra, rb, $urandom_range(0, 3), s, c, v, lat, fb, fcin);
      exp = ref_model(rop, ra, rb);
      check("rand sum", 32'(s), 32'(exp[15:0]));
      check("rand carry", 32'(c), 32'(exp[17]));
      check("rand ovf", 32'(v), 32'(exp[16]));
      check("rand latency", 32'(lat), 32'd5);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
